// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative RV32M multiply/divide unit.
// Helpers operate on up to 64-bit operands; callers pass the live width.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   function automatic logic [63:0] width_mask(input int w);
      width_mask = (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [63:0] abs_val(input logic [63:0] x,
                                           input int w,
                                           input logic sgn);
      logic [63:0] m;
      m = width_mask(w);
      if (sgn && x[w-1])
         abs_val = (~x + 64'd1) & m;
      else
         abs_val = x & m;
   endfunction

   function automatic logic is_min_int(input logic [63:0] x,
                                       input int w);
      is_min_int = x[w-1] && ((x & width_mask(w-1)) == 64'd0);
   endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath: one quotient bit per step.
// start loads magnitudes; step shifts and conditionally subtracts.
module div_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvs_q;
   logic [XLEN:0]   r_sh;
   logic [XLEN:0]   diff;

   always_comb begin
      r_sh = {rem_q, quo_q[XLEN-1]};
      diff = r_sh - {1'b0, dvs_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (start) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
      end else if (step) begin
         // remainder stays below divisor, so r_sh fits XLEN+1 bits
         if (!diff[XLEN]) begin
            rem_q <= diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_q <= r_sh[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready accept and done pulse.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier on MUL* ops.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic            kill_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic [XLEN-1:0] result_o,
   output logic            done_o
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   logic [2:0]        state;
   logic [2:0]        nstate;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic              negp;
   logic              negr;
   logic [XLEN-1:0]   mcand;
   logic [2*XLEN-1:0] prod;

   logic              accept;
   logic              is_div;
   logic              s1;
   logic              s2;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              div0;
   logic              ovf;
   logic              skip;
   logic [XLEN-1:0]   skip_res;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [2*XLEN-1:0] pfix;
   logic [XLEN-1:0]   qfix;
   logic [XLEN-1:0]   rfix;
   logic [XLEN-1:0]   fix_res;
   logic [2*XLEN-1:0] prod_nxt;

   always_comb begin
      accept = valid_i && ready_o && !kill_i;
      is_div = op_i[2];
      s1 = (op_i == OP_MUL) || (op_i == OP_MULH) ||
           (op_i == OP_MULHSU) || (op_i == OP_DIV) ||
           (op_i == OP_REM);
      s2 = (op_i == OP_MUL) || (op_i == OP_MULH) ||
           (op_i == OP_DIV) || (op_i == OP_REM);
      a_mag = XLEN'(abs_val(64'(rs1_i), XLEN, s1));
      b_mag = XLEN'(abs_val(64'(rs2_i), XLEN, s2));
      div0 = is_div && (rs2_i == '0);
      ovf = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
            is_min_int(64'(rs1_i), XLEN) && (&rs2_i);
      skip = div0 || ovf;
      // REM* ops have op bit 1 set
      if (div0)
         skip_res = op_i[1] ? rs1_i : '1;
      else
         skip_res = op_i[1] ? '0 : rs1_i;
   end

`ifdef MULDIV_FAST_MUL_EN
   always_comb begin
      prod_nxt = {{XLEN{1'b0}}, mcand} *
                 {{XLEN{1'b0}}, prod[XLEN-1:0]};
   end
`else
   logic [XLEN:0] sum;
   always_comb begin
      sum = {1'b0, prod[2*XLEN-1:XLEN]} +
            (prod[0] ? {1'b0, mcand} : '0);
      prod_nxt = {sum, prod[XLEN-1:1]};
   end
`endif

   always_comb begin
      pfix = negp ? -prod : prod;
      qfix = negp ? -quo : quo;
      rfix = negr ? -rem : rem;
      if (op_q[2])
         fix_res = op_q[1] ? rfix : qfix;
      else if (op_q == OP_MUL)
         fix_res = pfix[XLEN-1:0];
      else
         fix_res = pfix[2*XLEN-1:XLEN];
   end

   always_comb begin
      nstate = state;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (accept)
               nstate = skip ? ST_DONE :
                        (is_div ? ST_DIV : ST_MUL);
            else
               nstate = ST_IDLE;
         end
`ifdef MULDIV_FAST_MUL_EN
         ST_MUL: nstate = ST_FIX;
`else
         ST_MUL: if (cnt == '0) nstate = ST_FIX;
`endif
         ST_DIV: if (cnt == '0) nstate = ST_FIX;
         ST_FIX: nstate = ST_DONE;
         default: nstate = ST_IDLE;
      endcase
      if (kill_i)
         nstate = ST_IDLE;
   end

   div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (accept && is_div),
      .step      (state == ST_DIV),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (quo),
      .remainder (rem)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         ready_o  <= 1'b1;
         done_o   <= 1'b0;
         result_o <= '0;
         cnt      <= '0;
         op_q     <= '0;
         negp     <= 1'b0;
         negr     <= 1'b0;
         mcand    <= '0;
         prod     <= '0;
      end else begin
         state   <= nstate;
         ready_o <= (nstate == ST_IDLE) || (nstate == ST_DONE);
         done_o  <= (nstate == ST_DONE);
         if (accept) begin
            op_q  <= op_i;
            cnt   <= CNT_W'(XLEN - 1);
            mcand <= a_mag;
            prod  <= {{XLEN{1'b0}}, b_mag};
            negp  <= (s1 & rs1_i[XLEN-1]) ^ (s2 & rs2_i[XLEN-1]);
            negr  <= s1 & rs1_i[XLEN-1];
            if (skip)
               result_o <= skip_res;
         end else begin
            if (state == ST_MUL) begin
               prod <= prod_nxt;
               cnt  <= cnt - 1'b1;
            end
            if (state == ST_DIV)
               cnt <= cnt - 1'b1;
            if ((state == ST_FIX) && !kill_i)
               result_o <= fix_res;
         end
      end
   end

endmodule
